// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request feeding
// a 2-entry {pc, inst} FIFO toward ID, with flush and drop handling.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc_i,
  input  logic        if_ce_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic        issue;
  logic        push;
  logic        pop;

  assign issue = (state == IDLE) && if_ce_i
              && !flush_i && (count != 2'd2);
  assign push  = (state == WAIT) && imem_ack_i && !flush_i;
  assign pop   = (count != 2'd0) && !id_stall_i && !flush_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (imem_ack_i)   state_nxt = IDLE;
        else if (flush_i) state_nxt = DROP;
      end
      DROP: if (imem_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      imem_req_o <= 1'b0;
      req_pc     <= 32'd0;
    end else begin
      state      <= state_nxt;
      imem_req_o <= (state_nxt != IDLE);
      if (issue) req_pc <= if_pc_i;
    end
  end

  // Flush wins over push/pop and realigns both pointers.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr]   <= req_pc;
      fifo_inst[wptr] <= imem_rdata_i;
    end
  end

  assign imem_addr_o = req_pc;
  assign id_valid_o  = (count != 2'd0);
  assign id_pc_o     = id_valid_o ? fifo_pc[rptr]   : 32'd0;
  assign id_inst_o   = id_valid_o ? fifo_inst[rptr] : 32'd0;

  assign stallreq_o = (state != IDLE) || (count == 2'd2)
                   || (if_ce_i && (state == IDLE)
                       && !flush_i && !issue);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a queue-based model of the fetch stage.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc_i = '0;
  logic        if_ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  // Model: pending request, whether its data is doomed, and the queue
  bit          m_known = 0;
  bit          m_pend = 0;
  bit          m_kill = 0;
  logic [31:0] m_pc = '0;
  logic [63:0] m_q[$];
  int          pushes = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc_i      (if_pc_i),
    .if_ce_i      (if_ce_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_valid_o   (id_valid_o),
    .stallreq_o   (stallreq_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  task automatic compare();
    logic [31:0] epc;
    logic [31:0] ein;
    bit          full;
    bit          sreq;
    full = (m_q.size() == 2);
    epc  = m_q.size() != 0 ? m_q[0][63:32] : 32'd0;
    ein  = m_q.size() != 0 ? m_q[0][31:0]  : 32'd0;
    sreq = m_pend || full
        || (if_ce_i && !m_pend && !flush_i && full);
    check("req",   {31'd0, imem_req_o}, {31'd0, m_pend});
    if (m_pend)
      check("addr", imem_addr_o, m_pc);
    check("valid", {31'd0, id_valid_o},
          {31'd0, m_q.size() != 0});
    check("id_pc",   id_pc_o,   epc);
    check("id_inst", id_inst_o, ein);
    check("stall", {31'd0, stallreq_o}, {31'd0, sreq});
  endtask

  task automatic advance();
    bit ack_eff;
    bit deliver;
    bit pop;
    bit issue;
    if (rst) begin
      m_known = 1;
      m_pend  = 0;
      m_kill  = 0;
      m_pc    = '0;
      m_q.delete();
      return;
    end
    ack_eff = m_pend && imem_ack_i;
    deliver = ack_eff && !m_kill && !flush_i;
    pop     = (m_q.size() != 0) && !id_stall_i && !flush_i;
    issue   = !m_pend && if_ce_i && !flush_i && (m_q.size() < 2);
    if (flush_i) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (deliver) begin
        m_q.push_back({m_pc, imem_rdata_i});
        pushes++;
      end
    end
    if (ack_eff) begin
      m_pend = 0;
      m_kill = 0;
    end else if (m_pend && flush_i) m_kill = 1;
    if (issue) begin
      m_pend = 1;
      m_pc   = if_pc_i;
    end
  endtask

  task automatic cyc(input logic r, ce, fl, st, ak,
                     input logic [31:0] pc, rd);
    rst          = r;
    if_ce_i      = ce;
    flush_i      = fl;
    id_stall_i   = st;
    imem_ack_i   = ak;
    if_pc_i      = pc;
    imem_rdata_i = rd;
    #1;
    if (m_known) compare();
    advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int p0;
    // Reset, then fetch 0x0 acked in the first request cycle
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 1, 0, 1, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 1, 32'h4, 32'h24010005);
    check("lat_valid", {31'd0, id_valid_o}, 32'd1);
    check("lat_pc",    id_pc_o,   32'h0);
    check("lat_inst",  id_inst_o, 32'h24010005);

    // 3-cycle ack latency: one push, address held
    p0 = pushes;
    cyc(0, 1, 1, 0, 0, 32'h8, 32'h0);
    cyc(0, 1, 0, 0, 0, 32'h10, 32'h0);
    for (int i = 0; i < 2; i++)
      cyc(0, 1, 0, 0, 0, 32'h14 + 4 * i, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h0, 32'hAAAA0010);
    check("one_push", pushes - p0, 32'd1);
    cyc(0, 0, 1, 0, 0, 32'h0, 32'h0);

    // ID stalled: fetch 0x0 and 0x4, FIFO fills, no new request
    cyc(0, 1, 0, 1, 0, 32'h0, 32'h0);
    cyc(0, 1, 0, 1, 1, 32'h4, 32'h11111111);
    cyc(0, 1, 0, 1, 0, 32'h4, 32'h0);
    cyc(0, 1, 0, 1, 1, 32'h8, 32'h22222222);
    cyc(0, 1, 0, 1, 0, 32'h8, 32'h0);
    check("full_stall", {31'd0, stallreq_o}, 32'd1);
    check("full_noreq", {31'd0, imem_req_o}, 32'd0);
    check("head0", id_pc_o, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h8, 32'h0);
    check("head1", id_pc_o, 32'h4);
    cyc(0, 0, 0, 0, 0, 32'h8, 32'h0);

    // Flush in WAIT, late ack discarded, next issue from 0x100
    cyc(0, 1, 0, 0, 0, 32'h40, 32'h0);
    cyc(0, 0, 1, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h0, 32'hDEADBEEF);
    check("drop_valid", {31'd0, id_valid_o}, 32'd0);
    cyc(0, 1, 0, 0, 0, 32'h100, 32'h0);
    check("new_addr", imem_addr_o, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'h0, 32'h33333333);

    // Reset mid-WAIT with one entry queued
    cyc(0, 1, 0, 1, 0, 32'h200, 32'h0);
    check("pre_rst_cnt", {31'd0, id_valid_o}, 32'd1);
    cyc(1, 0, 0, 1, 0, 32'h0, 32'h0);
    check("rst_req",   {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, id_valid_o}, 32'd0);
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);

    // Randomized traffic in phases of differing pressure
    for (int ph = 0; ph < 6; ph++) begin
      int pa;
      int ps;
      int pf;
      int pc;
      pa = 20 + 15 * ph;
      ps = (ph % 3) * 30;
      pf = (ph == 2) ? 20 : 4;
      pc = 50 + 8 * ph;
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(999) < 3,
            $urandom_range(99) < pc,
            $urandom_range(99) < pf,
            $urandom_range(99) < ps,
            $urandom_range(99) < pa,
            $urandom & 32'hFFFF_FFFC,
            $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
